// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the serial pattern detector run-controller.
//   State encoding constants, default parameter widths and a small state helper.
package seq_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned PAT_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 3;
    localparam int unsigned TMO_W_DEF = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ARMED  = 3'd1;
    localparam logic [2:0] HUNT   = 3'd2;
    localparam logic [2:0] REPORT = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    // States in which a run is in progress
    function automatic logic is_busy(input logic [STATE_W-1:0] st);
        return (st == HUNT) || (st == REPORT);
    endfunction

endpackage

// File: rtl/seq_shift_match.sv
// seq_shift_match: serial shift register, fill counter and pattern comparator.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   clear    in   synchronous clear of shift register and fill count
//   shift    in   accept bit_in this cycle
//   bit_in   in   serial data bit
//   pattern  in   PAT_W-bit pattern, first-received bit is MSB
//   match_c  out  combinational: the bit being shifted in completes a match
module seq_shift_match
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    output logic             match_c
);

    localparam int unsigned       FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  shreg;
    logic [PAT_W-1:0]  shreg_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;

    // Match is judged on the window that includes the bit being accepted
    always_comb begin
        shreg_nxt = {shreg[PAT_W-2:0], bit_in};
        fill_nxt  = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
        match_c   = shift && (fill_nxt == FILL_MAX) && (shreg_nxt == pattern);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            fill  <= '0;
        end else if (clear) begin
            shreg <= '0;
            fill  <= '0;
        end else if (shift) begin
            shreg <= shreg_nxt;
            fill  <= fill_nxt;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-controller for the serial pattern detector.
//   Latches pattern/limit/timeout on the config handshake, hunts the bit stream for
//   (overlapping) matches and reports each one as an event over valid/ready.
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_valid/cfg_ready      config handshake (ready only in IDLE)
//   cfg_pattern/limit/timeout  run configuration (limit/timeout 0 = disabled)
//   start, abort             ARMED->HUNT pulse; return to IDLE from anywhere
//   bit_valid/bit_ready/bit_in  serial bit stream
//   evt_valid/evt_ready/evt_count  match event port, 1-based match index
//   busy, done, timed_out    run status (done is a pulse, timed_out is sticky)
module seq_det_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned TMO_W = TMO_W_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             bit_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic             busy,
    output logic             done,
    output logic             timed_out
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [PAT_W-1:0]   pattern_q;
    logic [PAT_W-1:0]   pattern_nxt;
    logic [CNT_W-1:0]   limit_q;
    logic [CNT_W-1:0]   limit_nxt;
    logic [TMO_W-1:0]   timeout_q;
    logic [TMO_W-1:0]   timeout_nxt;
    logic [CNT_W-1:0]   match_cnt;
    logic [CNT_W-1:0]   match_cnt_nxt;
    logic [TMO_W-1:0]   idle_cnt;
    logic [TMO_W-1:0]   idle_cnt_nxt;
    logic [CNT_W-1:0]   evt_count_nxt;
    logic               timed_out_nxt;
    logic               shift_c;
    logic               clear_c;
    logic               match_c;

    // bit_ready is only high in HUNT, so the handshake alone qualifies the shift
    assign shift_c = bit_valid && bit_ready && !abort && (state == HUNT);

    seq_shift_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_c),
        .shift   (shift_c),
        .bit_in  (bit_in),
        .pattern (pattern_q),
        .match_c (match_c)
    );

    // Next-state, counter and config-latch logic
    always_comb begin
        state_nxt     = state;
        pattern_nxt   = pattern_q;
        limit_nxt     = limit_q;
        timeout_nxt   = timeout_q;
        match_cnt_nxt = match_cnt;
        idle_cnt_nxt  = idle_cnt;
        evt_count_nxt = evt_count;
        timed_out_nxt = timed_out;
        clear_c       = 1'b0;

        if (abort) begin
            state_nxt     = IDLE;
            clear_c       = 1'b1;
            match_cnt_nxt = '0;
            idle_cnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        pattern_nxt   = cfg_pattern;
                        limit_nxt     = cfg_limit;
                        timeout_nxt   = cfg_timeout;
                        timed_out_nxt = 1'b0;
                        state_nxt     = ARMED;
                    end
                end
                ARMED: begin
                    if (start) begin
                        clear_c       = 1'b1;
                        match_cnt_nxt = '0;
                        idle_cnt_nxt  = '0;
                        state_nxt     = HUNT;
                    end
                end
                HUNT: begin
                    if (shift_c) begin
                        if (match_c) begin
                            match_cnt_nxt = match_cnt + CNT_W'(1);
                            evt_count_nxt = match_cnt_nxt;
                            idle_cnt_nxt  = '0;
                            state_nxt     = REPORT;
                        end else begin
                            idle_cnt_nxt = idle_cnt + TMO_W'(1);
                            if ((timeout_q != '0) && (idle_cnt_nxt == timeout_q)) begin
                                timed_out_nxt = 1'b1;
                                state_nxt     = DONE;
                            end
                        end
                    end
                end
                REPORT: begin
                    if (evt_valid && evt_ready) begin
                        if ((limit_q != '0) && (match_cnt == limit_q)) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = HUNT;
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs (outputs decoded from next state)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pattern_q <= '0;
            limit_q   <= '0;
            timeout_q <= '0;
            match_cnt <= '0;
            idle_cnt  <= '0;
            evt_count <= '0;
            timed_out <= 1'b0;
            cfg_ready <= 1'b1;
            bit_ready <= 1'b0;
            evt_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pattern_q <= pattern_nxt;
            limit_q   <= limit_nxt;
            timeout_q <= timeout_nxt;
            match_cnt <= match_cnt_nxt;
            idle_cnt  <= idle_cnt_nxt;
            evt_count <= evt_count_nxt;
            timed_out <= timed_out_nxt;
            cfg_ready <= (state_nxt == IDLE);
            bit_ready <= (state_nxt == HUNT);
            evt_valid <= (state_nxt == REPORT);
            busy      <= is_busy(state_nxt);
            // DONE lasts exactly one cycle, so this is a pulse
            done      <= (state_nxt == DONE);
        end
    end

endmodule
